// File: rtl/npu_buf_pkg.sv
// Shared sizing for the NPU buffer RAM and its arbiter.
package npu_buf_pkg;

  localparam int unsigned NPU_W = 16;
  localparam int unsigned NPU_D = 512;
  localparam int unsigned NPU_N = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DAW   = $clog2(NPU_D);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, last-winner pointer
// that only moves on a completed transfer.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] win;
  logic          found;

  // Search for the first requester strictly after the last winner, modulo N
  always_comb begin
    gnt   = '0;
    win   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= int'(N); k++) begin
      if (!found && req[IW'((int'(ptr_q) + k) % int'(N))]) begin
        found = 1'b1;
        win   = IW'((int'(ptr_q) + k) % int'(N));
      end
    end
    if (found) begin
      gnt[win] = 1'b1;
    end
  end

  // Pointer follows the winner only when the grant was actually taken
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = win;
    end
  end

  // Pointer register; N-1 after reset gives client 0 first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_sdp_arbiter.sv
// Shares one simple dual-port RAM between N clients with independent
// round-robin arbitration of the write and read ports; read responses come
// back one cycle later tagged with the issuing client id.
// Optional macro RAM_ARB_FWD_EN: same-cycle write/read to one address
// returns the new data (write-first) instead of the old RAM contents.
module ram_sdp_arbiter
  import npu_buf_pkg::*;
#(
  parameter int unsigned W  = NPU_W,
  parameter int unsigned D  = NPU_D,
  parameter int unsigned N  = NPU_N,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    wr_req,
  input  logic [N*AW-1:0] wr_addr,
  input  logic [N*W-1:0]  wr_data,
  output logic [N-1:0]    wr_gnt,
  input  logic [N-1:0]    rd_req,
  input  logic [N*AW-1:0] rd_addr,
  output logic [N-1:0]    rd_gnt,
  output logic            rsp_vld,
  output logic [IW-1:0]   rsp_id,
  output logic [W-1:0]    rsp_data,
  output logic            ram_we,
  output logic [AW-1:0]   ram_write_addr,
  output logic [W-1:0]    ram_din,
  output logic            ram_re,
  output logic [AW-1:0]   ram_read_addr,
  input  logic            ram_dout_vld,
  input  logic [W-1:0]    ram_dout
);

  localparam int unsigned CMPW = $clog2(D);

  // Reject configurations the arbiter cannot serve
  if (N < 2 || CMPW > AW) begin : g_bad_cfg
    $error("ram_sdp_arbiter: need N >= 2 and $clog2(D) <= 32");
  end

  logic          wr_xfer_c;
  logic          rd_xfer_c;
  logic [IW-1:0] rd_id_c;
  logic          pend_vld_q;
  logic          pend_vld_d;
  logic [IW-1:0] pend_id_q;
  logic [IW-1:0] pend_id_d;

  rr_arbiter #(.N(N)) u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (wr_req),
    .advance (wr_xfer_c),
    .gnt     (wr_gnt)
  );

  rr_arbiter #(.N(N)) u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rd_req),
    .advance (rd_xfer_c),
    .gnt     (rd_gnt)
  );

  // Write port mux from the one-hot winner; all zero when idle
  always_comb begin
    ram_write_addr = '0;
    ram_din        = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (wr_gnt[i]) begin
        ram_write_addr = wr_addr[i*AW +: AW];
        ram_din        = wr_data[i*W +: W];
      end
    end
    ram_we    = |wr_gnt;
    wr_xfer_c = |(wr_req & wr_gnt);
  end

  // Read port mux and winner id for response tagging
  always_comb begin
    ram_read_addr = '0;
    rd_id_c       = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (rd_gnt[i]) begin
        ram_read_addr = rd_addr[i*AW +: AW];
        rd_id_c       = IW'(i);
      end
    end
    ram_re    = |rd_gnt;
    rd_xfer_c = |(rd_req & rd_gnt);
  end

  // Track the read in flight so its response carries the issuer id
  always_comb begin
    pend_vld_d = rd_xfer_c;
    pend_id_d  = pend_id_q;
    if (rd_xfer_c) begin
      pend_id_d = rd_id_c;
    end
  end

  // Response tag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q <= 1'b0;
      pend_id_q  <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_id_q  <= pend_id_d;
    end
  end

  assign rsp_vld = pend_vld_q;
  assign rsp_id  = pend_id_q;

`ifdef RAM_ARB_FWD_EN
  logic         fwd_vld_q;
  logic         fwd_vld_d;
  logic [W-1:0] fwd_data_q;
  logic [W-1:0] fwd_data_d;

  // Detect a same-cycle write and read to the same RAM word
  always_comb begin
    fwd_vld_d  = wr_xfer_c && rd_xfer_c &&
                 (ram_write_addr[CMPW-1:0] == ram_read_addr[CMPW-1:0]);
    fwd_data_d = fwd_data_q;
    if (fwd_vld_d) begin
      fwd_data_d = ram_din;
    end
  end

  // Forwarded write data, consumed on the response cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_vld_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_vld_q  <= fwd_vld_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign rsp_data = fwd_vld_q ? fwd_data_q : ram_dout;
`else
  assign rsp_data = ram_dout;
`endif

  // The response slot must line up with the RAM's read-return valid
  a_pend_matches_ram: assert property (
    @(posedge clk) disable iff (!rst_n) pend_vld_q == ram_dout_vld
  );

endmodule
